adc_serial_rx: RTL and testbench

Serial ADC capture front end for a 16-bit-frame SPI-style converter: 4 leading zeros, then a 12-bit MSB-first sample. The block generates the converter's chip-select and serial clock from the system clock and deserialises each frame. It presents an 8-bit sample with a one-cycle valid strobe, so the result can drive the 8-bit `sdata` input of the downstream DAC serial driver directly. It is the stage immediately upstream of that driver in the ADC-to-DAC loopback path.

---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_sclk_gen.sv | 56 +++++
 rtl/adc_serial_rx.sv | 118 +++++++++++
 tb/tb_adc_serial_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared frame geometry and FSM state encoding for the serial ADC capture path.
package adc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_BITS  = 12;
  localparam int OUT_BITS   = 8;
  localparam int BIT_CNT_W  = 5;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT_CNT = BIT_CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    QUIET
  } adc_state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// ADC serial clock generator: CLK_DIV clocks per phase, starting with a high setup
// phase, plus strobes flagging the clk edge that moves adc_sclk low->high or high->low.
module adc_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic hold_high_i,
  output logic adc_sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int              PH_W    = $clog2(CLK_DIV + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            sclk_q, sclk_d;
  logic            tick;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    tick     = run_i && (phase_q == PH_LAST);
    rise_stb = tick && !sclk_q;
    fall_stb = tick && sclk_q;
    phase_d  = phase_q;
    sclk_d   = sclk_q;
    if (!run_i) begin
      phase_d = '0;
      sclk_d  = 1'b1;
    end else if (tick) begin
      phase_d = '0;
      // The final high phase must not fall: the frame ends with sclk parked high.
      sclk_d  = (fall_stb && hold_high_i) ? 1'b1 : ~sclk_q;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      sclk_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign adc_sclk = sclk_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Serial ADC front end: drives cs_n/sclk for 16-bit frames (4 lead zeros + 12 data bits)
// and delivers the sample with a one-cycle valid strobe.
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = 1,
  parameter int QUIET_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [OUT_BITS-1:0]  sample,
  output logic [DATA_BITS-1:0] sample_raw,
  output logic                 sample_valid,
  output logic                 frame_err
);

  localparam int            QW         = $clog2(QUIET_CYCLES);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

  adc_state_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [QW-1:0]           quiet_q, quiet_d;
  logic                    cs_n_q, cs_n_d;
  logic [OUT_BITS-1:0]     sample_q, sample_d;
  logic [DATA_BITS-1:0]    raw_q, raw_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic in_conv, last_bit, frame_done, rise_stb, fall_stb;

  assign in_conv    = (state_q == CONV);
  assign last_bit   = (bit_cnt_q == LAST_BIT_CNT);
  // The fall tick after the 16th capture closes the 16th high phase.
  assign frame_done = fall_stb && last_bit;

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (in_conv),
    .hold_high_i (last_bit),
    .adc_sclk    (adc_sclk),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      quiet_q   <= '0;
      cs_n_q    <= 1'b1;
      sample_q  <= '0;
      raw_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      quiet_q   <= quiet_d;
      cs_n_q    <= cs_n_d;
      sample_q  <= sample_d;
      raw_q     <= raw_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = CONV;
      CONV:    if (frame_done) state_d = QUIET;
      QUIET:   if (quiet_q == QUIET_LAST) state_d = enable ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture happens on the same edge that raises sclk; counters idle at zero outside CONV.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (!in_conv) begin
      bit_cnt_d = '0;
    end else if (rise_stb) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      shift_d   = {shift_q[FRAME_BITS-2:0], adc_sdata};
    end
    quiet_d = (state_q == QUIET) ? quiet_q + 1'b1 : '0;
  end

  always_comb begin
    cs_n_d   = (state_d != CONV);
    valid_d  = frame_done;
    err_d    = frame_done && (|shift_q[FRAME_BITS-1 -: LEAD_ZEROS]);
    raw_d    = raw_q;
    sample_d = sample_q;
    if (frame_done) begin
      raw_d    = shift_q[DATA_BITS-1:0];
      sample_d = shift_q[DATA_BITS-1 -: OUT_BITS];
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign sample       = sample_q;
  assign sample_raw   = raw_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: two instances (CLK_DIV=1 and 3) with an ADC model each,
// a per-cycle frame-level reference check, and directed literal expectations.
module tb_adc_serial_rx;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] en = '0;
  logic [15:0] adc_word [2];
  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  cs_o, sclk_o, valid_o, err_o;
  logic [7:0]  sample_o [2];
  logic [11:0] raw_o    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int DIV = (g == 0) ? 1 : 3;

    logic        cs_n, sclk, valid, err;
    logic        sdata = 1'b0;
    logic [7:0]  sample;
    logic [11:0] raw;

    adc_serial_rx #(
      .CLK_DIV     (DIV),
      .QUIET_CYCLES(3)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (en[g]),
      .adc_sdata   (sdata),
      .adc_cs_n    (cs_n),
      .adc_sclk    (sclk),
      .sample      (sample),
      .sample_raw  (raw),
      .sample_valid(valid),
      .frame_err   (err)
    );

    assign cs_o[g]     = cs_n;
    assign sclk_o[g]   = sclk;
    assign valid_o[g]  = valid;
    assign err_o[g]    = err;
    assign sample_o[g] = sample;
    assign raw_o[g]    = raw;

    // ADC: latches its word when selected, presents word bit 15-k after the k-th sclk fall.
    logic [15:0] adc_cur   = '0;
    int          adc_falls = 0;
    always @(negedge cs_n or negedge sclk) begin
      if (sclk) begin
        adc_cur   = adc_word[g];
        adc_falls = 0;
      end else if (!cs_n && adc_falls < 16) begin
        #1;
        sdata = adc_cur[15 - adc_falls];
        adc_falls++;
      end
    end

    // Frame-level reference: result due 33*DIV clocks after cs_n falls, equal to the
    // low 12 bits of the word the ADC held; sclk phases all DIV long; 16 rises per frame.
    int          fall_cyc = 0, last_tog = 0, rises = 0;
    bit          active = 1'b0, exp_valid = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1;
    logic [15:0] frame_word  = '0;
    logic [7:0]  hold_sample = '0;
    logic [11:0] hold_raw    = '0;

    always @(negedge clk) begin
      if (!rst_n) begin
        check($sformatf("ch%0d_rst_cs_n", g), cs_n, 1);
        check($sformatf("ch%0d_rst_sclk", g), sclk, 1);
        check($sformatf("ch%0d_rst_valid", g), valid, 0);
        check($sformatf("ch%0d_rst_err", g), err, 0);
        check($sformatf("ch%0d_rst_raw", g), raw, 0);
        active      = 1'b0;
        prev_cs     = 1'b1;
        prev_sclk   = 1'b1;
        hold_sample = '0;
        hold_raw    = '0;
      end else begin
        if (prev_cs && !cs_n) begin
          active     = 1'b1;
          fall_cyc   = cyc;
          last_tog   = cyc;
          rises      = 0;
          frame_word = adc_word[g];
        end
        exp_valid = active && ((cyc - fall_cyc) == 33 * DIV);
        if (exp_valid) begin
          hold_raw    = frame_word % 16'h1000;
          hold_sample = 8'(hold_raw / 16);
        end
        check($sformatf("ch%0d_valid", g), valid, exp_valid);
        check($sformatf("ch%0d_frame_err", g), err, exp_valid && (frame_word >= 16'h1000));
        check($sformatf("ch%0d_sample", g), sample, hold_sample);
        check($sformatf("ch%0d_sample_raw", g), raw, hold_raw);
        if (cs_n) check($sformatf("ch%0d_sclk_idle_high", g), sclk, 1);
        if (active && sclk != prev_sclk) begin
          check($sformatf("ch%0d_sclk_phase", g), cyc - last_tog, DIV);
          if (sclk) rises++;
          last_tog = cyc;
        end
        if (exp_valid) begin
          check($sformatf("ch%0d_cs_n_end", g), cs_n, 1);
          check($sformatf("ch%0d_last_high", g), cyc - last_tog, DIV);
          check($sformatf("ch%0d_rises", g), rises, 16);
          active = 1'b0;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
      end
    end
  end

  task automatic wait_cs_low(input int g, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (!cs_o[g]) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    check("cs_fall_timeout", at >= 0, 1);
  endtask

  task automatic wait_valid(input int g, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_o[g]) begin
        at = cyc;
        break;
      end
    end
    check("valid_timeout", at >= 0, 1);
  endtask

  task automatic wait_rises(input int g, input int n);
    int   r = 0;
    logic ps = sclk_o[g];
    for (int i = 0; i < 400 && r < n; i++) begin
      @(negedge clk);
      if (sclk_o[g] && !ps) r++;
      ps = sclk_o[g];
    end
    check("rises_seen", r, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          f, v, vprev;
    bit          ok;
    logic [15:0] b2b_words [3];
    logic [7:0]  b2b_samp  [3];
    b2b_words = '{16'h0FFF, 16'h0000, 16'h0800};
    b2b_samp  = '{8'hFF, 8'h00, 8'h80};
    adc_word[0] = '0;
    adc_word[1] = '0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cs_n", cs_o[0], 1);
    check("reset_sclk", sclk_o[0], 1);
    check("reset_sample", sample_o[0], 0);
    check("reset_valid", valid_o[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, one-clock enable pulse.
    adc_word[0] = 16'h0ABC;
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    wait_cs_low(0, 10, f);
    wait_valid(0, 100, v);
    check("t1_latency", v - f, 33);
    check("t1_sample_raw", raw_o[0], 12'hABC);
    check("t1_sample", sample_o[0], 8'hAB);
    check("t1_frame_err", err_o[0], 0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!cs_o[0]) ok = 1'b0;
    end
    check("t1_idle_cs_high", ok, 1);

    // Back-to-back with enable held.
    adc_word[0] = b2b_words[0];
    en[0] = 1'b1;
    vprev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_cs_low(0, 50, f);
      if (i > 0) check("t2_quiet_len", f - vprev, 3);
      wait_valid(0, 100, v);
      check("t2_sample", sample_o[0], b2b_samp[i]);
      if (i > 0) check("t2_spacing", v - vprev, 36);
      vprev = v;
      if (i < 2) adc_word[0] = b2b_words[i+1];
      else       en[0] = 1'b0;
    end
    repeat (10) @(negedge clk);

    // Leading bit set: frame error.
    adc_word[0] = 16'h8123;
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    wait_cs_low(0, 10, f);
    wait_valid(0, 100, v);
    check("t3_sample_raw", raw_o[0], 12'h123);
    check("t3_sample", sample_o[0], 8'h12);
    check("t3_frame_err", err_o[0], 1);
    repeat (10) @(negedge clk);

    // CLK_DIV = 3 instance.
    adc_word[1] = 16'h05A5;
    en[1] = 1'b1;
    @(negedge clk);
    en[1] = 1'b0;
    wait_cs_low(1, 10, f);
    wait_valid(1, 200, v);
    check("t4_latency", v - f, 99);
    check("t4_sample", sample_o[1], 8'h5A);
    check("t4_sample_raw", raw_o[1], 12'h5A5);
    check("t4_frame_err", err_o[1], 0);
    repeat (10) @(negedge clk);

    // Reset after the 7th sclk rise; then a complete frame.
    adc_word[0] = 16'h0777;
    en[0] = 1'b1;
    wait_rises(0, 7);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs_n", cs_o[0], 1);
    check("t5_sclk", sclk_o[0], 1);
    check("t5_sample", sample_o[0], 0);
    check("t5_sample_raw", raw_o[0], 0);
    check("t5_valid", valid_o[0], 0);
    repeat (2) @(negedge clk);
    adc_word[0] = 16'h0C3D;
    #2 rst_n = 1'b1;
    @(negedge clk);
    wait_cs_low(0, 10, f);
    wait_valid(0, 100, v);
    check("t5_latency", v - f, 33);
    check("t5_after_raw", raw_o[0], 12'hC3D);
    en[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Enable drop after the 5th rise: frame completes, then idle.
    adc_word[0] = 16'h0456;
    en[0] = 1'b1;
    wait_rises(0, 5);
    en[0] = 1'b0;
    wait_valid(0, 100, v);
    check("t6_sample_raw", raw_o[0], 12'h456);
    check("t6_sample", sample_o[0], 8'h45);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!cs_o[0]) ok = 1'b0;
    end
    check("t6_no_new_frame", ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
